ethernet_receiver_multislot: RTL and testbench

//  AXI-Stream RX frame buffer between MAC RX and host read port; next-gen receiver with slot_p packet slots in a ring.

---
 rtl/eth_rx_pkg.sv | 39 +++
 rtl/eth_rx_slot_mem.sv | 97 +++++++++
 rtl/ethernet_receiver_multislot.sv | 235 +++++++++++++++++++++++
 tb/tb_ethernet_receiver_multislot.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and helpers for the multi-slot Ethernet RX frame buffer.
// Included by the slot memory and the receiver top.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP_FULL,
    DROP_OVS
  } rx_state_e;

  typedef enum logic [1:0] {
    OP_1B,
    OP_2B,
    OP_4B,
    OP_8B
  } op_size_e;

  localparam int unsigned KEEP_MAX = 16;

  // Byte count of a beat: highest set keep bit plus one.
  function automatic logic [4:0] keep_to_bytes(
    input logic [KEEP_MAX-1:0] keep
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (keep[i]) n = 5'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_slot_mem.sv
// Frame storage: 1R1W byte-lane memory across all slots,
// per-slot size table and the host read byte-lane select.
module eth_rx_slot_mem
  import eth_rx_pkg::*;
#(
  parameter int unsigned data_width_p = 64,
  parameter int unsigned buf_size_p   = 2048,
  parameter int unsigned slot_p       = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          wr_v_i,
  input  logic [$clog2(slot_p)-1:0]     wr_slot_i,
  input  logic [$clog2(buf_size_p)-1:0] wr_addr_i,
  input  logic [data_width_p-1:0]       wr_data_i,
  input  logic                          size_v_i,
  input  logic [$clog2(slot_p)-1:0]     size_slot_i,
  input  logic [15:0]                   size_i,
  input  logic [$clog2(slot_p)-1:0]     head_i,
  output logic [15:0]                   head_size_o,
  input  logic                          rd_v_i,
  input  logic [$clog2(buf_size_p)-1:0] rd_addr_i,
  input  logic [1:0]                    rd_op_i,
  output logic [63:0]                   rd_data_o
);

  localparam int unsigned SLOT_W = $clog2(slot_p);
  localparam int unsigned ADDR_W = $clog2(buf_size_p);
  localparam int unsigned BEAT_B = data_width_p / 8;
  // Rows are at least 64 bits so an 8-byte read is one row.
  localparam int unsigned ROW_W  =
    (data_width_p > 64) ? data_width_p : 64;
  localparam int unsigned ROW_B  = ROW_W / 8;
  localparam int unsigned ROW_AW = $clog2(ROW_B);
  localparam int unsigned ROWS   = slot_p * buf_size_p / ROW_B;
  localparam int unsigned RIDX_W = SLOT_W + ADDR_W - ROW_AW;

  logic [ROW_W-1:0]  mem_q [ROWS];
  logic [15:0]       size_q [slot_p];
  logic [RIDX_W-1:0] wr_idx;
  logic [RIDX_W-1:0] rd_idx;
  logic [ROW_AW-1:0] wr_lane;
  logic [ROW_W-1:0]  wr_row;
  logic [ROW_B-1:0]  wr_be;
  logic [ROW_W-1:0]  rd_row;
  logic [ROW_W-1:0]  rd_shift;
  logic [63:0]       rd_mask;
  logic [63:0]       rd_data_d;
  logic [63:0]       rd_data_q;

  always_comb begin
    wr_idx  = {wr_slot_i, wr_addr_i[ADDR_W-1:ROW_AW]};
    rd_idx  = {head_i, rd_addr_i[ADDR_W-1:ROW_AW]};
    wr_lane = wr_addr_i[ROW_AW-1:0];
    wr_row  = ROW_W'(wr_data_i) << {wr_lane, 3'b000};
    wr_be   = ROW_B'({BEAT_B{1'b1}}) << wr_lane;
  end

  always_ff @(posedge clk_i) begin
    if (wr_v_i) begin
      for (int b = 0; b < ROW_B; b++) begin
        if (wr_be[b]) mem_q[wr_idx][b*8 +: 8] <= wr_row[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < slot_p; s++) size_q[s] <= '0;
    end else if (size_v_i) begin
      size_q[size_slot_i] <= size_i;
    end
  end

  assign head_size_o = size_q[head_i];

  always_comb begin
    rd_row   = mem_q[rd_idx];
    rd_shift = rd_row >> {rd_addr_i[ROW_AW-1:0], 3'b000};
    unique case (op_size_e'(rd_op_i))
      OP_1B: rd_mask = 64'h0000_0000_0000_00FF;
      OP_2B: rd_mask = 64'h0000_0000_0000_FFFF;
      OP_4B: rd_mask = 64'h0000_0000_FFFF_FFFF;
      OP_8B: rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    rd_data_d = rd_data_q;
    if (rd_v_i) rd_data_d = rd_shift[63:0] & rd_mask;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rd_data_q <= '0;
    else            rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ethernet_receiver_multislot.sv
// AXI-Stream RX frame buffer: write FSM, slot ring pointers,
// drop counters. Never backpressures the MAC.
module ethernet_receiver_multislot
  import eth_rx_pkg::*;
#(
  parameter int unsigned data_width_p = 64,
  parameter int unsigned buf_size_p   = 2048,
  parameter int unsigned slot_p       = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [data_width_p-1:0]         rx_axis_tdata_i,
  input  logic [data_width_p/8-1:0]       rx_axis_tkeep_i,
  input  logic                            rx_axis_tvalid_i,
  output logic                            rx_axis_tready_o,
  input  logic                            rx_axis_tlast_i,
  input  logic                            rx_axis_tuser_i,
  output logic                            ready_o,
  output logic [15:0]                     rx_packet_size_o,
  input  logic                            buffer_read_v_i,
  input  logic [$clog2(buf_size_p)-1:0]   buffer_read_addr_i,
  input  logic [1:0]                      buffer_read_op_size_i,
  output logic [63:0]                     buffer_read_data_o,
  input  logic                            clear_buffer_i,
  output logic [$clog2(slot_p+1)-1:0]     slots_used_o,
  output logic [15:0]                     good_count_o,
  output logic [15:0]                     drop_err_count_o,
  output logic [15:0]                     drop_oversize_count_o,
  output logic [15:0]                     drop_full_count_o
);

  localparam int unsigned BEAT_B = data_width_p / 8;
  localparam int unsigned BEAT_AW = $clog2(BEAT_B);
  localparam int unsigned ADDR_W = $clog2(buf_size_p);
  localparam int unsigned SLOT_W = $clog2(slot_p);
  localparam int unsigned USED_W = $clog2(slot_p + 1);
  localparam int unsigned BEATS  = buf_size_p / BEAT_B;
  localparam int unsigned PTR_W  = $clog2(BEATS + 1);

  logic [1:0]        rst_sync_d, rst_sync_q;
  logic              rst_n;
  rx_state_e         state_d, state_q;
  logic [PTR_W-1:0]  beat_ptr_d, beat_ptr_q;
  logic [SLOT_W-1:0] head_d, head_q;
  logic [SLOT_W-1:0] tail_d, tail_q;
  logic [USED_W-1:0] used_d, used_q;
  logic [15:0]       good_d, good_q;
  logic [15:0]       err_d, err_q;
  logic [15:0]       ovs_d, ovs_q;
  logic [15:0]       full_d, full_q;
  logic              tready_d, tready_q;

  logic [15:0]       beat_bytes;
  logic [15:0]       base_bytes;
  logic [15:0]       frame_size;
  logic [ADDR_W-1:0] wr_addr;
  logic              ring_full;
  logic              at_limit;
  logic              ovs_beat;
  logic              wr_v;
  logic              done;
  logic              commit;
  logic              clr;
  logic [15:0]       head_size;

  // Async assert, two-flop synchronous release.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= '0;
    else            rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  always_comb begin
    beat_bytes = 16'(keep_to_bytes(KEEP_MAX'(rx_axis_tkeep_i)));
    base_bytes = 16'(beat_ptr_q) << BEAT_AW;
    frame_size = base_bytes + beat_bytes;
    wr_addr    = ADDR_W'(beat_ptr_q) << BEAT_AW;
    ring_full  = used_q == USED_W'(slot_p);
    at_limit   = beat_ptr_q == PTR_W'(BEATS);
    ovs_beat   = at_limit && (beat_bytes != 16'd0);
    clr        = clear_buffer_i && (used_q != '0);
  end

  always_comb begin
    state_d    = state_q;
    beat_ptr_d = beat_ptr_q;
    tail_d     = tail_q;
    good_d     = good_q;
    err_d      = err_q;
    ovs_d      = ovs_q;
    full_d     = full_q;
    wr_v       = 1'b0;
    done       = 1'b0;
    commit     = 1'b0;
    if (rx_axis_tvalid_i) begin
      unique case (state_q)
        IDLE: begin
          if (ring_full) begin
            if (rx_axis_tlast_i) full_d = sat_inc(full_q);
            else                 state_d = DROP_FULL;
          end else begin
            wr_v       = 1'b1;
            beat_ptr_d = PTR_W'(1);
            if (rx_axis_tlast_i) done = 1'b1;
            else                 state_d = RECV;
          end
        end
        RECV: begin
          if (ovs_beat) begin
            if (rx_axis_tlast_i) begin
              ovs_d   = sat_inc(ovs_q);
              state_d = IDLE;
            end else begin
              state_d = DROP_OVS;
            end
          end else begin
            wr_v = !at_limit;
            if (!at_limit) beat_ptr_d = beat_ptr_q + PTR_W'(1);
            if (rx_axis_tlast_i) done = 1'b1;
          end
        end
        DROP_FULL: begin
          if (rx_axis_tlast_i) begin
            full_d  = sat_inc(full_q);
            state_d = IDLE;
          end
        end
        DROP_OVS: begin
          if (rx_axis_tlast_i) begin
            ovs_d   = sat_inc(ovs_q);
            state_d = IDLE;
          end
        end
      endcase
    end
    if (done) begin
      state_d = IDLE;
      if (rx_axis_tuser_i || frame_size == 16'd0) begin
        err_d = sat_inc(err_q);
      end else begin
        commit = 1'b1;
        tail_d = tail_q + SLOT_W'(1);
        good_d = sat_inc(good_q);
      end
    end
    if (state_d == IDLE) beat_ptr_d = '0;
  end

  always_comb begin
    head_d   = head_q + SLOT_W'(clr);
    used_d   = used_q + USED_W'(commit) - USED_W'(clr);
    tready_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_ptr_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      used_q     <= '0;
      good_q     <= '0;
      err_q      <= '0;
      ovs_q      <= '0;
      full_q     <= '0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_ptr_q <= beat_ptr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      used_q     <= used_d;
      good_q     <= good_d;
      err_q      <= err_d;
      ovs_q      <= ovs_d;
      full_q     <= full_d;
      tready_q   <= tready_d;
    end
  end

  eth_rx_slot_mem #(
    .data_width_p (data_width_p),
    .buf_size_p   (buf_size_p),
    .slot_p       (slot_p)
  ) u_mem (
    .clk_i        (clk_i),
    .reset_n_i    (rst_n),
    .wr_v_i       (wr_v),
    .wr_slot_i    (tail_q),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (rx_axis_tdata_i),
    .size_v_i     (commit),
    .size_slot_i  (tail_q),
    .size_i       (frame_size),
    .head_i       (head_q),
    .head_size_o  (head_size),
    .rd_v_i       (buffer_read_v_i),
    .rd_addr_i    (buffer_read_addr_i),
    .rd_op_i      (buffer_read_op_size_i),
    .rd_data_o    (buffer_read_data_o)
  );

  assign rx_axis_tready_o      = tready_q;
  assign ready_o               = used_q != '0;
  assign rx_packet_size_o      = ready_o ? head_size : 16'd0;
  assign slots_used_o          = used_q;
  assign good_count_o          = good_q;
  assign drop_err_count_o      = err_q;
  assign drop_oversize_count_o = ovs_q;
  assign drop_full_count_o     = full_q;

`ifndef SYNTHESIS
  logic misaligned;

  always_comb begin
    unique case (op_size_e'(buffer_read_op_size_i))
      OP_1B: misaligned = 1'b0;
      OP_2B: misaligned = buffer_read_addr_i[0];
      OP_4B: misaligned = |buffer_read_addr_i[1:0];
      OP_8B: misaligned = |buffer_read_addr_i[2:0];
    endcase
  end

  a_read_ready: assert property (@(posedge clk_i) disable iff (!rst_n)
    buffer_read_v_i |-> ready_o);
  a_clear_ready: assert property (@(posedge clk_i) disable iff (!rst_n)
    clear_buffer_i |-> ready_o);
  a_read_align: assert property (@(posedge clk_i) disable iff (!rst_n)
    buffer_read_v_i |-> !misaligned);
`endif

endmodule

// File: tb/tb_ethernet_receiver_multislot.sv
// Randomized bench for ethernet_receiver_multislot against a
// frame-level model of the slot ring and drop counters.
module tb_ethernet_receiver_multislot;

  localparam int DW = 64;
  localparam int BUF = 2048;
  localparam int SLOTS = 4;
  localparam int NB = DW / 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic        ready_o;
  logic [15:0] pkt_size;
  logic        rd_v;
  logic [10:0] rd_addr;
  logic [1:0]  rd_op;
  logic [63:0] rd_data;
  logic        clear;
  logic [2:0]  used;
  logic [15:0] good_c, err_c, ovs_c, full_c;

  always #5 clk = ~clk;

  ethernet_receiver_multislot #(
    .data_width_p (DW),
    .buf_size_p   (BUF),
    .slot_p       (SLOTS)
  ) dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .rx_axis_tdata_i       (tdata),
    .rx_axis_tkeep_i       (tkeep),
    .rx_axis_tvalid_i      (tvalid),
    .rx_axis_tready_o      (tready),
    .rx_axis_tlast_i       (tlast),
    .rx_axis_tuser_i       (tuser),
    .ready_o               (ready_o),
    .rx_packet_size_o      (pkt_size),
    .buffer_read_v_i       (rd_v),
    .buffer_read_addr_i    (rd_addr),
    .buffer_read_op_size_i (rd_op),
    .buffer_read_data_o    (rd_data),
    .clear_buffer_i        (clear),
    .slots_used_o          (used),
    .good_count_o          (good_c),
    .drop_err_count_o      (err_c),
    .drop_oversize_count_o (ovs_c),
    .drop_full_count_o     (full_c)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] mdata [SLOTS][BUF];
  int         msize [SLOTS];
  int         mhead, mcount;
  int         e_good, e_err, e_ovs, e_full;
  logic [7:0] fb [BUF+16];

  function automatic logic [63:0] mread(input int addr, input int op);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < (1 << op); i++) v[i*8 +: 8] = mdata[mhead][addr+i];
    return v;
  endfunction

  function automatic int exp_size();
    return (mcount > 0) ? msize[mhead] : 0;
  endfunction

  task automatic model_reset();
    mhead = 0; mcount = 0;
    e_good = 0; e_err = 0; e_ovs = 0; e_full = 0;
  endtask

  task automatic send_frame(input int n, input bit err,
                            input bit clr_last, input bit gaps);
    int nb, tail, prior, cnt;
    bit commit;
    nb = (n == 0) ? 1 : (n + NB - 1) / NB;
    for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
    prior = mcount;
    tail = (mhead + mcount) % SLOTS;
    commit = 1'b0;
    if (mcount == SLOTS) e_full++;
    else if (n > BUF) e_ovs++;
    else if (err || n == 0) e_err++;
    else commit = 1'b1;
    for (int b = 0; b < nb; b++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        tvalid = 1'b0;
        tdata = {$urandom, $urandom};
        @(negedge clk);
      end
      cnt = n - b * NB;
      if (cnt > NB) cnt = NB;
      for (int k = 0; k < NB; k++)
        tdata[k*8 +: 8] = (k < cnt) ? fb[b*NB+k] : 8'($urandom);
      tkeep = 8'((16'd1 << cnt) - 16'd1);
      tvalid = 1'b1;
      tlast = (b == nb - 1);
      tuser = (b == nb - 1) ? err : 1'($urandom);
      clear = clr_last && (b == nb - 1);
      @(negedge clk);
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; clear = 1'b0;
    if (commit) begin
      for (int i = 0; i < n; i++) mdata[tail][i] = fb[i];
      msize[tail] = n;
      mcount++;
      e_good++;
    end
    if (clr_last && prior > 0) begin
      mhead = (mhead + 1) % SLOTS;
      mcount--;
    end
  endtask

  task automatic clear_head();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mhead = (mhead + 1) % SLOTS;
    mcount--;
  endtask

  task automatic rd(input int addr, input int op, output logic [63:0] d);
    rd_v = 1'b1;
    rd_addr = 11'(addr);
    rd_op = 2'(op);
    @(negedge clk);
    rd_v = 1'b0;
    d = rd_data;
  endtask

  task automatic read_head_random(output logic [63:0] got,
                                  output logic [63:0] exp, output int a);
    int sz, op;
    sz = msize[mhead];
    op = $urandom_range(0, 3);
    while ((1 << op) > sz) op--;
    a = $urandom_range(0, (sz >> op) - 1) << op;
    rd(a, op, got);
    exp = mread(a, op);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    rd_v = 1'b0; rd_addr = '0; rd_op = '0; clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (tready !== 1'b0) begin
      errors++; $display("FAIL reset_tready: got %b want 0", tready);
    end
    checks++;
    if ({ready_o, pkt_size, rd_data, used, good_c, err_c, ovs_c, full_c} !== '0) begin
      errors++; $display("FAIL reset_outputs: got ready=%b size=%0d used=%0d counts=%0d/%0d/%0d/%0d want all 0",
        ready_o, pkt_size, used, good_c, err_c, ovs_c, full_c);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (tready !== 1'b1 || ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: got tready=%b ready=%b want 1 0", tready, ready_o);
    end
  endtask

  task automatic test_basic();
    logic [63:0] got, exp, held;
    int a;
    send_frame(60, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ready_o !== 1'b1 || pkt_size !== 16'd60 || good_c !== 16'd1) begin
      errors++; $display("FAIL basic_commit: got ready=%b size=%0d good=%0d want 1 60 1", ready_o, pkt_size, good_c);
    end
    rd(4, 2, got);
    exp = {32'd0, fb[7], fb[6], fb[5], fb[4]};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL basic_read4: got %h want %h", got, exp);
    end
    held = got;
    rd_addr = 11'd0; rd_op = 2'd3;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_data !== held) begin
      errors++; $display("FAIL basic_hold: got %h want %h", rd_data, held);
    end
    for (int r = 0; r < 6; r++) begin
      read_head_random(got, exp, a);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL basic_rand_read a=%0d: got %h want %h", a, got, exp);
      end
    end
    clear_head();
    checks++;
    if (ready_o !== 1'b0 || pkt_size !== 16'd0 || used !== 3'd0) begin
      errors++; $display("FAIL basic_clear: got ready=%b size=%0d used=%0d want 0 0 0", ready_o, pkt_size, used);
    end
  endtask

  task automatic test_drop_full();
    logic [63:0] got, exp;
    int a;
    for (int f = 0; f < 5; f++) send_frame($urandom_range(1, 120), 1'b0, 1'b0, 1'b1);
    checks++;
    if (used !== 3'd4 || full_c !== 16'(e_full) || good_c !== 16'(e_good)) begin
      errors++; $display("FAIL full_fill: got used=%0d full=%0d good=%0d want 4 %0d %0d", used, full_c, good_c, e_full, e_good);
    end
    clear_head();
    send_frame($urandom_range(9, 150), 1'b0, 1'b0, 1'b1);
    checks++;
    if (used !== 3'd4 || good_c !== 16'(e_good) || full_c !== 16'(e_full)) begin
      errors++; $display("FAIL full_refill: got used=%0d good=%0d full=%0d want 4 %0d %0d", used, good_c, full_c, e_good, e_full);
    end
    repeat (3) clear_head();
    checks++;
    if (pkt_size !== 16'(exp_size())) begin
      errors++; $display("FAIL full_newest_size: got %0d want %0d", pkt_size, exp_size());
    end
    read_head_random(got, exp, a);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL full_newest_read a=%0d: got %h want %h", a, got, exp);
    end
    clear_head();
  endtask

  task automatic test_oversize();
    logic [63:0] got, exp;
    send_frame(BUF, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pkt_size !== 16'(BUF) || good_c !== 16'(e_good)) begin
      errors++; $display("FAIL ovs_exact: got size=%0d good=%0d want %0d %0d", pkt_size, good_c, BUF, e_good);
    end
    rd(BUF - 8, 3, got);
    exp = mread(BUF - 8, 3);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL ovs_tail_read: got %h want %h", got, exp);
    end
    send_frame(BUF + 8, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovs_c !== 16'd1 || used !== 3'd1 || good_c !== 16'(e_good)) begin
      errors++; $display("FAIL ovs_drop: got ovs=%0d used=%0d good=%0d want 1 1 %0d", ovs_c, used, good_c, e_good);
    end
    send_frame(50, 1'b0, 1'b0, 1'b1);
    clear_head();
    checks++;
    if (used !== 3'd1 || pkt_size !== 16'd50) begin
      errors++; $display("FAIL ovs_next: got used=%0d size=%0d want 1 50", used, pkt_size);
    end
    clear_head();
  endtask

  task automatic test_err();
    send_frame(30, 1'b1, 1'b0, 1'b1);
    checks++;
    if (err_c !== 16'(e_err) || used !== 3'd0) begin
      errors++; $display("FAIL err_tuser: got err=%0d used=%0d want %0d 0", err_c, used, e_err);
    end
    send_frame(0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (err_c !== 16'(e_err) || used !== 3'd0 || ready_o !== 1'b0) begin
      errors++; $display("FAIL err_zero: got err=%0d used=%0d ready=%b want %0d 0 0", err_c, used, ready_o, e_err);
    end
    send_frame(77, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pkt_size !== 16'd77 || good_c !== 16'(e_good)) begin
      errors++; $display("FAIL err_after: got size=%0d good=%0d want 77 %0d", pkt_size, good_c, e_good);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got, exp;
    int a;
    while (mcount < 3) send_frame($urandom_range(1, 100), 1'b0, 1'b0, 1'b1);
    send_frame(40, 1'b0, 1'b1, 1'b0);
    checks++;
    if (used !== 3'd3 || pkt_size !== 16'(exp_size()) || good_c !== 16'(e_good)) begin
      errors++; $display("FAIL b2b_used: got used=%0d size=%0d good=%0d want 3 %0d %0d", used, pkt_size, good_c, exp_size(), e_good);
    end
    read_head_random(got, exp, a);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL b2b_read a=%0d: got %h want %h", a, got, exp);
    end
  endtask

  task automatic test_random();
    logic [63:0] got, exp;
    int act, n, a, sel;
    for (int it = 0; it < 60; it++) begin
      act = $urandom_range(0, 9);
      if (act < 5) begin
        sel = $urandom_range(0, 19);
        if (sel == 0) n = 0;
        else if (sel == 1) n = $urandom_range(BUF - 8, BUF + 12);
        else n = $urandom_range(1, 300);
        send_frame(n, $urandom_range(0, 7) == 0, 1'b0, 1'b1);
      end else if (act < 7) begin
        if (mcount > 0) clear_head();
      end else if (mcount > 0) begin
        read_head_random(got, exp, a);
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL rand_read it=%0d a=%0d: got %h want %h", it, a, got, exp);
        end
      end
      checks++;
      if (used !== 3'(mcount) || pkt_size !== 16'(exp_size())) begin
        errors++; $display("FAIL rand_ring it=%0d: got used=%0d size=%0d want %0d %0d", it, used, pkt_size, mcount, exp_size());
      end
      checks++;
      if ({good_c, err_c, ovs_c, full_c} !==
          {16'(e_good), 16'(e_err), 16'(e_ovs), 16'(e_full)}) begin
        errors++; $display("FAIL rand_counts it=%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
          it, good_c, err_c, ovs_c, full_c, e_good, e_err, e_ovs, e_full);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got, exp;
    int a;
    for (int b = 0; b < 3; b++) begin
      tdata = {$urandom, $urandom}; tkeep = 8'hFF; tvalid = 1'b1;
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    tvalid = 1'b0;
    #1;
    checks++;
    if ({tready, ready_o, pkt_size, rd_data, used, good_c, err_c, ovs_c, full_c} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got tready=%b ready=%b used=%0d good=%0d data=%h want all 0",
        tready, ready_o, used, good_c, rd_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    send_frame(100, 1'b0, 1'b0, 1'b1);
    checks++;
    if (used !== 3'd1 || pkt_size !== 16'd100 || good_c !== 16'd1) begin
      errors++; $display("FAIL midreset_frame: got used=%0d size=%0d good=%0d want 1 100 1", used, pkt_size, good_c);
    end
    read_head_random(got, exp, a);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL midreset_read a=%0d: got %h want %h", a, got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop_full();
    test_oversize();
    test_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
